// File: rtl/dvi_deserialiser.sv
// dvi_deserialiser: assembles 10-bit TMDS symbols from a DDR bit-pair stream and aligns on control tokens
// Ports:
//   clk        bit-pair clock (5x pixel clock)
//   rst_n      asynchronous active-low reset
//   d          serial bit pair, d[0] earlier (rise), d[1] later (fall); stream is LSB-first
//   resync     synchronous request to drop lock and slip once
//   sym        captured symbol, bit 0 is the earliest-received bit
//   sym_valid  one-cycle strobe, sym is new this cycle
//   locked     high while aligned on control tokens
//   alignment  current alignment index, 0..9
module dvi_deserialiser #(
    parameter int LOCK_THRESHOLD = 4,
    parameter int SEARCH_DWELL   = 2048,
    parameter int LOCK_TIMEOUT   = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] d,
    input  logic       resync,
    output logic [9:0] sym,
    output logic       sym_valid,
    output logic       locked,
    output logic [3:0] alignment
);
    localparam int RW = $clog2(LOCK_THRESHOLD + 1);
    localparam int DW = $clog2(SEARCH_DWELL + 1);
    localparam int MW = $clog2(LOCK_TIMEOUT + 1);
    typedef enum logic {SEARCH, LOCKED} state_t;
    state_t        state_q, state_d;
    // Only the history bits the capture window can still reach are stored.
    logic [11:3]   sr_q;
    logic [11:1]   sr_d;
    logic [2:0]    phase_q, phase_d;
    logic          offset_q, offset_d;
    logic [9:0]    sym_q, sym_d, window;
    logic          sym_valid_q, sym_valid_d;
    logic [3:0]    align_q, align_d;
    logic [RW-1:0] run_q, run_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [MW-1:0] miss_q, miss_d;
    logic          is_ctl, fsm_slip, slip, stall, capture;

    assign is_ctl      = sym_q inside {10'h354, 10'h0AB, 10'h154, 10'h2AB};
    assign slip        = fsm_slip | resync;
    // Going from offset 0 to 1 moves the window one bit earlier; holding the
    // phase for one edge (two bits) makes the net move one bit later.
    assign stall       = slip & ~offset_q;
    assign capture     = (phase_q == 3'd4) & ~stall;
    assign sr_d        = {d, sr_q};
    assign window      = offset_q ? sr_d[10:1] : sr_d[11:2];
    assign phase_d     = stall ? phase_q : (phase_q == 3'd4 ? 3'd0 : phase_q + 3'd1);
    assign offset_d    = offset_q ^ slip;
    assign align_d     = slip ? (align_q == 4'd9 ? 4'd0 : align_q + 4'd1) : align_q;
    assign sym_d       = capture ? window : sym_q;
    assign sym_valid_d = capture;

    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        dwell_d  = dwell_q;
        miss_d   = miss_q;
        fsm_slip = 1'b0;
        if (sym_valid_q) begin
            if (state_q == SEARCH) begin
                if (is_ctl) begin
                    run_d   = run_q == RW'(LOCK_THRESHOLD) ? run_q : run_q + 1'b1;
                    dwell_d = '0;
                    if (run_q == RW'(LOCK_THRESHOLD - 1)) begin
                        state_d = LOCKED;
                        miss_d  = '0;
                    end
                end else begin
                    run_d   = '0;
                    dwell_d = dwell_q == DW'(SEARCH_DWELL) ? dwell_q : dwell_q + 1'b1;
                    if (dwell_q == DW'(SEARCH_DWELL - 1)) begin
                        fsm_slip = 1'b1;
                        dwell_d  = '0;
                    end
                end
            end else if (is_ctl) begin
                miss_d = '0;
            end else begin
                miss_d = miss_q == MW'(LOCK_TIMEOUT) ? miss_q : miss_q + 1'b1;
                if (miss_q == MW'(LOCK_TIMEOUT - 1)) begin
                    state_d = SEARCH;
                    run_d   = '0;
                    dwell_d = '0;
                end
            end
        end
        if (resync) begin
            state_d = SEARCH;
            run_d   = '0;
            dwell_d = '0;
            miss_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SEARCH;
            sr_q        <= '0;
            phase_q     <= '0;
            offset_q    <= 1'b0;
            sym_q       <= '0;
            sym_valid_q <= 1'b0;
            align_q     <= '0;
            run_q       <= '0;
            dwell_q     <= '0;
            miss_q      <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d[11:3];
            phase_q     <= phase_d;
            offset_q    <= offset_d;
            sym_q       <= sym_d;
            sym_valid_q <= sym_valid_d;
            align_q     <= align_d;
            run_q       <= run_d;
            dwell_q     <= dwell_d;
            miss_q      <= miss_d;
        end
    end

    assign sym       = sym_q;
    assign sym_valid = sym_valid_q;
    assign locked    = state_q == LOCKED;
    assign alignment = align_q;
endmodule

// File: tb/tb_dvi_deserialiser.sv
// tb_dvi_deserialiser: directed bench for dvi_deserialiser (reset, lock, resync/stall, timeout, misaligned search)
module tb_dvi_deserialiser;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       resync = 1'b0;
    logic [1:0] d = '0;
    logic [9:0] sym;
    logic       sym_valid, locked;
    logic [3:0] alignment;

    int         checks = 0, errors = 0;
    int         mode = 0, sidx = 0, slips = 0, ncap = 0, n = 0, hits = 0;
    logic       bq[$];
    logic       fb[$];
    logic [9:0] txs[$];
    logic [9:0] tx_const = 10'h354;
    logic [9:0] w, fs;
    logic [3:0] prev_align = '0;
    logic [9:0] ctl_tok [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    dvi_deserialiser #(
        .LOCK_THRESHOLD(4),
        .SEARCH_DWELL  (16),
        .LOCK_TIMEOUT  (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .d        (d),
        .resync   (resync),
        .sym      (sym),
        .sym_valid(sym_valid),
        .locked   (locked),
        .alignment(alignment)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1);
    end

    function automatic logic [9:0] frame_sym(input int i);
        return (i % 32 < 8) ? 10'h354 : 10'h1F0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refill();
        logic [9:0] s;
        s = mode == 0 ? 10'($urandom) : mode == 1 ? tx_const : mode == 2 ? frame_sym(sidx) : ctl_tok[sidx % 4];
        sidx++;
        txs.push_back(s);
        for (int i = 0; i < 10; i++) bq.push_back(s[i]);
    endtask

    task automatic drive();
        if (bq.size() < 2) refill();
        d[0] = bq.pop_front();
        d[1] = bq.pop_front();
    endtask

    task automatic step();
        @(negedge clk);
        if (sym_valid) ncap++;
        if (alignment != prev_align) slips++;
        prev_align = alignment;
        drive();
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!sym_valid && cnt < 12);
        if (!sym_valid) chk("valid_timeout", 32'(sym_valid), 1);
    endtask

    task automatic restart(input int m, input int s0, input int pre);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bq.delete();
        txs.delete();
        mode = m;
        sidx = s0;
        slips = 0;
        ncap = 0;
        prev_align = '0;
        for (int i = 0; i < pre; i++) bq.push_back(1'b0);
        drive();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive();
        repeat (120) step();
        // asynchronous reset in the middle of random traffic
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_sym", 32'(sym), 0);
        chk("rst_valid", 32'(sym_valid), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_align", 32'(alignment), 0);

        // aligned lock on repeated 10'h354
        tx_const = 10'h354;
        restart(1, 0, 0);
        repeat (4) step();
        chk("valid_early", 32'(sym_valid), 0);
        step();
        chk("valid_first", 32'(sym_valid), 1);
        chk("sym_first", 32'(sym), 32'h354);
        void'(txs.pop_front());
        for (int k = 1; k < 4; k++) begin
            wait_valid(n);
            chk("period", n, 5);
            chk("sym_aligned", 32'(sym), 32'(txs.pop_front()));
            chk("lock_early", 32'(locked), 0);
        end
        step();
        chk("locked", 32'(locked), 1);
        chk("align_0", 32'(alignment), 0);

        // resync from offset 0: stall gap, alignment 1, relock on mixed tokens
        wait_valid(n);
        chk("sym_pre_resync", 32'(sym), 32'(txs.pop_front()));
        chk("lock_pre_resync", 32'(locked), 1);
        mode = 3;
        sidx = 0;
        resync = 1'b1;
        bq.push_front(d[1]);
        d = {d[0], 1'b0};
        step();
        resync = 1'b0;
        chk("resync_unlock", 32'(locked), 0);
        chk("resync_align", 32'(alignment), 1);
        wait_valid(n);
        chk("stall_gap", n + 1, 6);
        chk("sym_post_slip", 32'(sym), 32'(txs.pop_front()));
        for (int k = 1; k < 4; k++) begin
            wait_valid(n);
            chk("relock_period", n, 5);
            chk("sym_relock", 32'(sym), 32'(txs.pop_front()));
            chk("relock_early", 32'(locked), 0);
        end
        step();
        chk("relocked", 32'(locked), 1);
        chk("relock_align", 32'(alignment), 1);

        // timeout after 8 non-control symbols while locked
        mode = 1;
        tx_const = 10'h1F0;
        wait_valid(n);
        chk("sym_last_ctl", 32'(sym), 32'(txs.pop_front()));
        step();
        chk("lock_hold", 32'(locked), 1);
        for (int k = 1; k <= 8; k++) begin
            wait_valid(n);
            chk("sym_miss", 32'(sym), 32'(txs.pop_front()));
            step();
            chk("timeout_lock", 32'(locked), 32'(k < 8));
        end
        chk("timeout_align", 32'(alignment), 1);

        // the frame must hold no control token at any wrong alignment
        for (int j = 0; j < 33; j++) begin
            fs = frame_sym(j);
            for (int i = 0; i < 10; i++) fb.push_back(fs[i]);
        end
        hits = 0;
        for (int s = 1; s < 10; s++)
            for (int j = 0; j < 32; j++) begin
                for (int i = 0; i < 10; i++) w[i] = fb[10 * j + s + i];
                if (w inside {10'h354, 10'h0AB, 10'h154, 10'h2AB}) hits++;
            end
        chk("frame_clean", hits, 0);

        // misaligned by 3 bits; frame starts at position 16 so alignment 3 meets the tokens
        restart(2, 16, 3);
        for (int k = 0; k < 80 && !locked; k++) begin
            wait_valid(n);
            step();
        end
        chk("mis_locked", 32'(locked), 1);
        chk("mis_slips", slips, 3);
        chk("mis_align", 32'(alignment), 3);
        chk("mis_lock_cap", ncap, 52);
        for (int k = 0; k < 6; k++) begin
            wait_valid(n);
            chk("mis_sym", 32'(sym), 32'(frame_sym(ncap - 1 + 16)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
